// File: rtl/keypad_pkg.sv
// Shared types and defaults for the keypad column scanner.
//   scan_state_t : SCAN (rotating columns) / HOLD (key captured, awaiting release)
//   DEF_*        : default parameter values
//   clog2_min1   : index/counter width helper that never returns 0
package keypad_pkg;

  typedef enum logic {
    SCAN = 1'b0,
    HOLD = 1'b1
  } scan_state_t;

  localparam int unsigned DEF_NUM_COLS       = 4;
  localparam int unsigned DEF_NUM_ROWS       = 4;
  localparam int unsigned DEF_DWELL_CYCLES   = 1000;
  localparam int unsigned DEF_RELEASE_CYCLES = 1000;
  localparam int unsigned DEF_DIR            = 0;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/row_prio_enc.sv
// Combinational row priority encoder.
//   rows  in  NUM_ROWS : row sample, active-high
//   idx   out          : index of the lowest set row bit (0 when none set)
//   any   out          : at least one row set
//   multi out          : more than one row set
module row_prio_enc
  import keypad_pkg::*;
#(
  parameter int unsigned NUM_ROWS = DEF_NUM_ROWS
) (
  input  logic [NUM_ROWS-1:0]                rows,
  output logic [clog2_min1(NUM_ROWS)-1:0]    idx,
  output logic                               any,
  output logic                               multi
);

  localparam int unsigned IW = clog2_min1(NUM_ROWS);

  logic found;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_ROWS; i++) begin
      if (rows[i] && !found) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

  assign any = |rows;
  // Clearing the lowest set bit leaves something only if a second bit was set.
  assign multi = |(rows & (rows - NUM_ROWS'(1)));

endmodule

// File: rtl/keypad_col_scanner.sv
// Column-scan engine for the matrix keypad front end.
//   clk, reset : clock, asynchronous active-high reset
//   en         : scan enable (ignored while a key is held)
//   row_sync   : synchronised rows, active-high = pressed
//   col_drive  : one-hot column strobe (1 << col_idx)
//   col_idx    : driven column index
//   held       : high while a captured key awaits release
//   key_valid  : one-cycle pulse on capture
//   key_row    : lowest pressed row of the captured sample
//   key_col    : column driven at capture
//   multi      : captured sample had more than one row set
// Rows are sampled only on the last clock of each column dwell. After a
// capture the column freezes until RELEASE_CYCLES consecutive all-zero row
// clocks are seen, then scanning resumes at the next column.
module keypad_col_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned NUM_COLS       = DEF_NUM_COLS,
  parameter int unsigned NUM_ROWS       = DEF_NUM_ROWS,
  parameter int unsigned DWELL_CYCLES   = DEF_DWELL_CYCLES,
  parameter int unsigned RELEASE_CYCLES = DEF_RELEASE_CYCLES,
  parameter int unsigned DIR            = DEF_DIR
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             en,
  input  logic [NUM_ROWS-1:0]              row_sync,
  output logic [NUM_COLS-1:0]              col_drive,
  output logic [$clog2(NUM_COLS)-1:0]      col_idx,
  output logic                             held,
  output logic                             key_valid,
  output logic [clog2_min1(NUM_ROWS)-1:0]  key_row,
  output logic [$clog2(NUM_COLS)-1:0]      key_col,
  output logic                             multi
);

  localparam int unsigned CIW = $clog2(NUM_COLS);
  localparam int unsigned RIW = clog2_min1(NUM_ROWS);
  localparam int unsigned CW  = clog2_min1((DWELL_CYCLES > RELEASE_CYCLES) ?
                                           DWELL_CYCLES : RELEASE_CYCLES);

  localparam logic [CW-1:0]  DWELL_LAST   = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0]  RELEASE_LAST = CW'(RELEASE_CYCLES - 1);
  localparam logic [CIW-1:0] COL_LAST     = CIW'(NUM_COLS - 1);
  localparam logic [NUM_COLS-1:0] DRIVE0  = NUM_COLS'(1);

  scan_state_t          state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [CIW-1:0]       idx_nxt, idx_adv;
  logic                 idx_bad;
  logic                 valid_nxt, multi_nxt;
  logic [RIW-1:0]       row_nxt;
  logic [CIW-1:0]       kcol_nxt;

  logic [RIW-1:0]       enc_idx;
  logic                 enc_any, enc_multi;

  row_prio_enc #(
    .NUM_ROWS (NUM_ROWS)
  ) u_enc (
    .rows  (row_sync),
    .idx   (enc_idx),
    .any   (enc_any),
    .multi (enc_multi)
  );

  assign held = (state == HOLD);

  // Out-of-range index is possible only for non-power-of-2 column counts.
  assign idx_bad = ({1'b0, col_idx} > {1'b0, COL_LAST});

  always_comb begin
    idx_adv = col_idx;
    if (DIR == 0) begin
      idx_adv = (col_idx == COL_LAST) ? '0 : col_idx + CIW'(1);
    end else begin
      idx_adv = (col_idx == '0) ? COL_LAST : col_idx - CIW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = col_idx;
    valid_nxt = 1'b0;
    row_nxt   = key_row;
    kcol_nxt  = key_col;
    multi_nxt = multi;

    unique case (state)
      SCAN: begin
        if (en) begin
          if (cnt == DWELL_LAST) begin
            cnt_nxt = '0;
            if (enc_any) begin
              state_nxt = HOLD;
              valid_nxt = 1'b1;
              row_nxt   = enc_idx;
              kcol_nxt  = col_idx;
              multi_nxt = enc_multi;
            end else begin
              idx_nxt = idx_adv;
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      HOLD: begin
        if (enc_any) begin
          cnt_nxt = '0;
        end else if (cnt == RELEASE_LAST) begin
          state_nxt = SCAN;
          cnt_nxt   = '0;
          idx_nxt   = idx_adv;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = SCAN;
    endcase

    if (idx_bad) begin
      idx_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      cnt       <= '0;
      col_idx   <= '0;
      col_drive <= DRIVE0;
      key_valid <= 1'b0;
      key_row   <= '0;
      key_col   <= '0;
      multi     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      col_idx   <= idx_nxt;
      col_drive <= DRIVE0 << idx_nxt;
      key_valid <= valid_nxt;
      key_row   <= row_nxt;
      key_col   <= kcol_nxt;
      multi     <= multi_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_col_scanner.sv
// Self-checking bench for keypad_col_scanner: two instances (DIR=0, DIR=1)
// share stimulus; each is compared every cycle against a behavioural model,
// with directed scenarios pinned by literal expectations, then random stimulus.
module tb_keypad_col_scanner;

  localparam int NC = 4;
  localparam int NR = 4;
  localparam int DW = 4;
  localparam int RL = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [3:0] row_sync = 4'b0;

  logic [3:0] cd0, cd1;
  logic [1:0] ci0, ci1, kr0, kr1, kc0, kc1;
  logic       h0, h1, kv0, kv1, m0, m1;

  keypad_col_scanner #(
    .NUM_COLS(NC), .NUM_ROWS(NR), .DWELL_CYCLES(DW), .RELEASE_CYCLES(RL), .DIR(0)
  ) dut0 (
    .clk(clk), .reset(reset), .en(en), .row_sync(row_sync),
    .col_drive(cd0), .col_idx(ci0), .held(h0), .key_valid(kv0),
    .key_row(kr0), .key_col(kc0), .multi(m0)
  );

  keypad_col_scanner #(
    .NUM_COLS(NC), .NUM_ROWS(NR), .DWELL_CYCLES(DW), .RELEASE_CYCLES(RL), .DIR(1)
  ) dut1 (
    .clk(clk), .reset(reset), .en(en), .row_sync(row_sync),
    .col_drive(cd1), .col_idx(ci1), .held(h1), .key_valid(kv1),
    .key_row(kr1), .key_col(kc1), .multi(m1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit hold;
    int cnt;
    int col;
    bit kv;
    int krow;
    int kcol;
    bit multi;
  } mod_t;

  mod_t md0, md1;

  function automatic mod_t mreset();
    mod_t s;
    s.hold = 0; s.cnt = 0; s.col = 0; s.kv = 0;
    s.krow = 0; s.kcol = 0; s.multi = 0;
    return s;
  endfunction

  function automatic int lowest(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i]) return i;
    return 0;
  endfunction

  function automatic mod_t mstep(input mod_t s, input int dir, input bit e, input logic [3:0] r);
    mod_t n;
    int step;
    n = s;
    step = (dir != 0) ? NC - 1 : 1;
    n.kv = 0;
    if (!s.hold) begin
      if (e) begin
        if (s.cnt == DW - 1) begin
          n.cnt = 0;
          if (r != 0) begin
            n.hold  = 1;
            n.kv    = 1;
            n.krow  = lowest(r);
            n.kcol  = s.col;
            n.multi = ($countones(r) > 1);
          end else begin
            n.col = (s.col + step) % NC;
          end
        end else begin
          n.cnt = s.cnt + 1;
        end
      end
    end else if (r != 0) begin
      n.cnt = 0;
    end else if (s.cnt == RL - 1) begin
      n.hold = 0;
      n.cnt  = 0;
      n.col  = (s.col + step) % NC;
    end else begin
      n.cnt = s.cnt + 1;
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      md0 <= mreset();
      md1 <= mreset();
    end else begin
      md0 <= mstep(md0, 0, en, row_sync);
      md1 <= mstep(md1, 1, en, row_sync);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("d0_col_drive", cd0, 1 << md0.col);
    chk("d0_col_idx",   ci0, md0.col);
    chk("d0_held",      h0,  md0.hold);
    chk("d0_key_valid", kv0, md0.kv);
    chk("d0_key_row",   kr0, md0.krow);
    chk("d0_key_col",   kc0, md0.kcol);
    chk("d0_multi",     m0,  md0.multi);
    chk("d1_col_drive", cd1, 1 << md1.col);
    chk("d1_col_idx",   ci1, md1.col);
    chk("d1_held",      h1,  md1.hold);
    chk("d1_key_valid", kv1, md1.kv);
    chk("d1_key_row",   kr1, md1.krow);
    chk("d1_key_col",   kc1, md1.kcol);
    chk("d1_multi",     m1,  md1.multi);
  end

  // ---------------- directed helpers ----------------
  task automatic edge_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_start(input int col);
    int n;
    n = 0;
    while (!(md0.col == col && md0.cnt == 0 && !md0.hold)) begin
      edge_n(1);
      n++;
      if (n > 64) begin
        total++;
        bad++;
        $display("FAIL wait_start timeout got=%0d want=%0d", md0.col, col);
        return;
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cd0"}, cd0, 4'b0001);
    chk({tag, "_ci0"}, ci0, 0);
    chk({tag, "_h0"},  h0,  0);
    chk({tag, "_kv0"}, kv0, 0);
    chk({tag, "_kr0"}, kr0, 0);
    chk({tag, "_kc0"}, kc0, 0);
    chk({tag, "_m0"},  m0,  0);
    chk({tag, "_cd1"}, cd1, 4'b0001);
    chk({tag, "_h1"},  h1,  0);
  endtask

  initial begin
    int n;

    edge_n(2);
    chk_reset_vals("rst");
    reset = 1'b0;
    en    = 1'b1;

    // Idle scan: 4 clocks per column, DIR=0 up, DIR=1 down.
    for (int k = 1; k <= 17; k++) begin
      edge_n(1);
      chk("idle_d0", cd0, 1 << ((k / 4) % 4));
      chk("idle_d1", cd1, 1 << ((4 - (k / 4) % 4) % 4));
      chk("idle_held", h0, 0);
      chk("idle_kv", kv0, 0);
    end

    // Capture at column 2.
    wait_start(2);
    row_sync = 4'b0100;
    edge_n(3);
    chk("cap_pre_held", h0, 0);
    edge_n(1);
    chk("cap_kv", kv0, 1);
    chk("cap_row", kr0, 2);
    chk("cap_col", kc0, 2);
    chk("cap_multi", m0, 0);
    chk("cap_held", h0, 1);
    chk("cap_drive", cd0, 4'b0100);

    // Release debounce: 0,0,glitch,0,0,0.
    row_sync = 4'b0;
    edge_n(1);
    chk("rel_kv_fall", kv0, 0);
    chk("rel_h1", h0, 1);
    edge_n(1);
    chk("rel_h2", h0, 1);
    row_sync = 4'b0001;
    edge_n(1);
    chk("rel_glitch", h0, 1);
    row_sync = 4'b0;
    edge_n(2);
    chk("rel_h5", h0, 1);
    chk("rel_drive_frozen", cd0, 4'b0100);
    edge_n(1);
    chk("rel_exit", h0, 0);
    chk("rel_drive", cd0, 4'b1000);
    chk("rel_row_kept", kr0, 2);

    // Multi-key at column 3, then wrap.
    row_sync = 4'b1010;
    edge_n(4);
    chk("mk_kv", kv0, 1);
    chk("mk_row", kr0, 1);
    chk("mk_col", kc0, 3);
    chk("mk_multi", m0, 1);
    row_sync = 4'b0;
    edge_n(3);
    chk("mk_exit", h0, 0);
    chk("mk_wrap", cd0, 4'b0001);

    // Enable gap of 5 clocks stretches the dwell to 9.
    edge_n(2);
    en = 1'b0;
    edge_n(5);
    chk("en_frozen", cd0, 4'b0001);
    en = 1'b1;
    n = 7;
    while (cd0 == 4'b0001 && n < 40) begin
      edge_n(1);
      n++;
    end
    chk("en_stretch", n, 9);
    chk("en_next", cd0, 4'b0010);

    // Async reset while held.
    row_sync = 4'b0001;
    edge_n(4);
    chk("ar_held", h0, 1);
    reset = 1'b1;
    #1;
    chk_reset_vals("ar");
    row_sync = 4'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      edge_n(1);
      chk("ar_resume", cd0, (k < 4) ? 4'b0001 : 4'b0010);
    end

    // Random phase.
    for (int c = 0; c < 3000; c++) begin
      edge_n(1);
      reset = ($urandom_range(0, 499) == 0);
      en    = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0)
        row_sync = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'b0;
    end
    reset = 1'b0;
    edge_n(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
